xnor_sram_bank: RTL

//  Multi-row successor of the single-row XNOR SRAM column array. Stores ROWS x COLUMN_NUM words of W bits.

---
 rtl/xnor_sram_pkg.sv | 35 +++
 rtl/xnor_popcnt_col.sv | 84 ++++++++
 rtl/xnor_sram_bank.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/xnor_sram_pkg.sv
// Shared definitions for the XNOR SRAM bank.
//   - precision mode encodings carried on cmd_mode
//   - FSM state encodings for the bank controller
//   - helpers that turn a mode into its lane mask and active bit count
package xnor_sram_pkg;

    localparam logic [2:0] MODE_1B = 3'd0;
    localparam logic [2:0] MODE_4B = 3'd1;
    localparam logic [2:0] MODE_8B = 3'd2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_ACC  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Bits of each word that take part in the XNOR count; unknown modes run at 8 bits.
    function automatic logic [7:0] mode_mask(input logic [2:0] mode);
        case (mode)
            MODE_1B: mode_mask = 8'h01;
            MODE_4B: mode_mask = 8'h0F;
            default: mode_mask = 8'hFF;
        endcase
    endfunction

    // Number of active bits per beat, used as the majority threshold weight.
    function automatic logic [3:0] mode_bits(input logic [2:0] mode);
        case (mode)
            MODE_1B: mode_bits = 4'd1;
            MODE_4B: mode_bits = 4'd4;
            default: mode_bits = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/xnor_popcnt_col.sv
// One column of the bank: XNOR of the snapshot word against the activation,
// precision mask, popcount, running accumulator and majority compare.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - clear the accumulator (LOAD state)
//   beat      - an activation beat is accepted this cycle
//   finish    - this edge enters DONE: capture p/q from the next accumulator value
//   mode, len - latched precision mode and beat count of the current op
//   snap, act - stored word and activation word for this column
//   p, q      - accumulated XNOR count and majority bit, held between results
module xnor_popcnt_col
    import xnor_sram_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 8,
    parameter int LW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             beat,
    input  logic             finish,
    input  logic [2:0]       mode,
    input  logic [LW-1:0]    len,
    input  logic [W-1:0]     snap,
    input  logic [W-1:0]     act,
    output logic [ACC_W-1:0] p,
    output logic             q
);

    localparam int CW = ACC_W + 1;

    logic [W-1:0]     mask_s;
    logic [W-1:0]     match_s;
    logic [ACC_W-1:0] pop_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_next_s;
    logic [CW-1:0]    twice_acc_s;
    logic [CW-1:0]    threshold_s;

    // Masked XNOR and its popcount for the current beat.
    always_comb begin
        mask_s  = W'(mode_mask(mode));
        match_s = ~(snap ^ act) & mask_s;
        pop_s   = '0;
        for (int i = 0; i < W; i++) begin
            pop_s = pop_s + ACC_W'(match_s[i]);
        end
    end

    // Next accumulator value; also what the result captures on DONE entry.
    always_comb begin
        if (load) begin
            acc_next_s = '0;
        end else if (beat) begin
            acc_next_s = acc_r + pop_s;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Majority compares 2*acc against len*bits so no division is needed.
    always_comb begin
        twice_acc_s = {acc_next_s, 1'b0};
        threshold_s = CW'(len) * CW'(mode_bits(mode));
    end

    // Accumulator and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
            p     <= '0;
            q     <= 1'b0;
        end else begin
            acc_r <= acc_next_s;
            if (finish) begin
                p <= acc_next_s;
                // An empty op reports no majority even though 0 >= 0.
                q <= (len != {LW{1'b0}}) && (twice_acc_s >= threshold_s);
            end
        end
    end

endmodule

// File: rtl/xnor_sram_bank.sv
// Multi-row XNOR SRAM bank with multi-beat XNOR-popcount accumulation.
// Ports:
//   clk, rst                    - clock and synchronous active-high reset
//   wr_en/wr_row/wr_data/wr_mask - masked row write, accepted in any state
//   cmd_valid/cmd_ready/cmd_row/cmd_len/cmd_mode - op request (ready only in IDLE)
//   act_valid/act_ready/act_data - activation beats (ready only in ACC)
//   res_valid/res_ready         - result handshake (valid only in DONE)
//   P, Q_out                    - per-column count and majority bit, held until next DONE
module xnor_sram_bank
    import xnor_sram_pkg::*;
#(
    parameter int COLUMN_NUM = 512,
    parameter int W          = 8,
    parameter int ROWS       = 16,
    parameter int MAX_LEN    = 16,
    localparam int ACC_W     = $clog2(MAX_LEN * W + 1),
    localparam int RW        = $clog2(ROWS),
    localparam int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [RW-1:0]               wr_row,
    input  logic [COLUMN_NUM*W-1:0]     wr_data,
    input  logic [COLUMN_NUM-1:0]       wr_mask,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [RW-1:0]               cmd_row,
    input  logic [LW-1:0]               cmd_len,
    input  logic [2:0]                  cmd_mode,
    input  logic                        act_valid,
    output logic                        act_ready,
    input  logic [COLUMN_NUM*W-1:0]     act_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [COLUMN_NUM*ACC_W-1:0] P,
    output logic [COLUMN_NUM-1:0]       Q_out
);

    localparam int RW1 = RW + 1;

    logic [COLUMN_NUM*W-1:0] mem_r [ROWS];
    logic [COLUMN_NUM*W-1:0] snap_r;
    state_t                  state_r;
    state_t                  state_next_s;
    logic [RW-1:0]           row_r;
    logic [LW-1:0]           len_r;
    logic [2:0]              mode_r;
    logic [LW-1:0]           beat_cnt_r;
    logic                    wr_row_ok_s;
    logic                    rd_row_ok_s;
    logic                    cmd_fire_s;
    logic                    load_s;
    logic                    beat_s;
    logic                    last_beat_s;
    logic                    finish_s;

    // Out-of-range rows only exist when ROWS is not a power of two.
    generate
        if ((1 << RW) == ROWS) begin : g_row_pow2
            assign wr_row_ok_s = 1'b1;
            assign rd_row_ok_s = 1'b1;
        end else begin : g_row_chk
            assign wr_row_ok_s = ({1'b0, wr_row} < RW1'(ROWS));
            assign rd_row_ok_s = ({1'b0, row_r}  < RW1'(ROWS));
        end
    endgenerate

    assign cmd_ready   = (state_r == ST_IDLE);
    assign act_ready   = (state_r == ST_ACC);
    assign res_valid   = (state_r == ST_DONE);
    assign cmd_fire_s  = cmd_valid && cmd_ready;
    assign load_s      = (state_r == ST_LOAD);
    assign beat_s      = act_valid && act_ready;
    assign last_beat_s = beat_s && ((beat_cnt_r + LW'(1)) == len_r);
    assign finish_s    = (load_s && (len_r == {LW{1'b0}})) || last_beat_s;

    // Weight memory: masked per-column writes, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                mem_r[r] <= '0;
            end
        end else if (wr_en && wr_row_ok_s) begin
            for (int j = 0; j < COLUMN_NUM; j++) begin
                if (wr_mask[j]) begin
                    mem_r[wr_row][j*W +: W] <= wr_data[j*W +: W];
                end
            end
        end
    end

    // Row snapshot taken in LOAD; later writes to the row do not disturb the op.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_r <= '0;
        end else if (load_s) begin
            snap_r <= rd_row_ok_s ? mem_r[row_r] : '0;
        end
    end

    // Command latch; over-long requests are clipped to MAX_LEN beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r  <= '0;
            len_r  <= '0;
            mode_r <= MODE_1B;
        end else if (cmd_fire_s) begin
            row_r  <= cmd_row;
            len_r  <= (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
            mode_r <= cmd_mode;
        end
    end

    // Accepted-beat counter for the current op.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r <= '0;
        end else if (load_s) begin
            beat_cnt_r <= '0;
        end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + LW'(1);
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (len_r == {LW{1'b0}}) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ACC;
                end
            end
            ST_ACC: begin
                if (last_beat_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ACC;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    generate
        for (genvar j = 0; j < COLUMN_NUM; j++) begin : g_col
            xnor_popcnt_col #(
                .W     (W),
                .ACC_W (ACC_W),
                .LW    (LW)
            ) u_col (
                .clk    (clk),
                .rst    (rst),
                .load   (load_s),
                .beat   (beat_s),
                .finish (finish_s),
                .mode   (mode_r),
                .len    (len_r),
                .snap   (snap_r[j*W +: W]),
                .act    (act_data[j*W +: W]),
                .p      (P[j*ACC_W +: ACC_W]),
                .q      (Q_out[j])
            );
        end
    endgenerate

endmodule
